// File: rtl/reservation_station_mf.sv
// Multi-frame reservation station for one E-node.
// Matches operands by frame/slot, issues round-robin, squashes failed predicates.
module reservation_station_mf #(
  parameter int FRAMES  = 8,
  parameter int NUM_IN  = 2,
  parameter int DATA_W  = 64,
  parameter int FRAME_W = $clog2(FRAMES)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      instr_load,
  input  logic [FRAME_W-1:0]        instr_frame,
  input  logic [2:0]                instr_need,
  input  logic [2:0]                instr_keep,
  input  logic                      instr_pred_true,
  input  logic [NUM_IN-1:0]         op_req,
  input  logic [NUM_IN*FRAME_W-1:0] op_frame,
  input  logic [NUM_IN*2-1:0]       op_slot,
  input  logic [NUM_IN*DATA_W-1:0]  op_data,
  output logic [NUM_IN-1:0]         op_ack,
  output logic                      fire_valid,
  input  logic                      fire_ready,
  output logic [FRAME_W-1:0]        fire_frame,
  output logic [DATA_W-1:0]         fire_left,
  output logic [DATA_W-1:0]         fire_right,
  output logic [FRAMES-1:0]         squash_mask,
  input  logic                      morph_s,
  input  logic                      revitalize,
  input  logic                      flush,
  input  logic [FRAME_W-1:0]        flush_frame,
  output logic [FRAME_W:0]          occupancy
);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_WAIT,
    ST_READY,
    ST_DONE
  } st_e;

  st_e               st_q   [FRAMES];
  st_e               st_d   [FRAMES];
  logic [2:0]        vld_q  [FRAMES];
  logic [2:0]        vld_d  [FRAMES];
  logic [2:0]        need_q [FRAMES];
  logic [2:0]        need_d [FRAMES];
  logic [2:0]        keep_q [FRAMES];
  logic [2:0]        keep_d [FRAMES];
  logic              pt_q   [FRAMES];
  logic              pt_d   [FRAMES];
  logic              prd_q  [FRAMES];
  logic              prd_d  [FRAMES];
  logic [DATA_W-1:0] lft_q  [FRAMES];
  logic [DATA_W-1:0] lft_d  [FRAMES];
  logic [DATA_W-1:0] rgt_q  [FRAMES];
  logic [DATA_W-1:0] rgt_d  [FRAMES];

  logic [FRAMES-1:0]  sq_q, sq_d;
  logic [FRAME_W:0]   occ_q, occ_d;
  logic [FRAME_W-1:0] rr_q, rr_d;
  logic [FRAME_W-1:0] lkf_q, lkf_d;
  logic               lk_q, lk_d;

  logic [FRAME_W-1:0] pf [NUM_IN];
  logic [1:0]         ps [NUM_IN];
  logic [DATA_W-1:0]  pd [NUM_IN];
  logic [NUM_IN-1:0]  ack;
  logic [FRAMES-1:0]  hit_ld, hit_fl, rdy;
  logic [FRAME_W-1:0] gnt, idx;
  logic               fv, acc, revit;

  // Slot 3 reads as permanently busy so it is always refused.
  function automatic logic slot_busy(logic [2:0] v, logic [1:0] s);
    logic [3:0] t;
    t = {1'b1, v};
    return t[s];
  endfunction

  function automatic st_e eval_st(logic [2:0] v, logic [2:0] need,
                                  logic pt, logic prd);
    if (v[2] && (prd != pt))
      return ST_DONE;
    else if ((v & need) == need)
      return ST_READY;
    else
      return ST_WAIT;
  endfunction

  assign revit = morph_s && revitalize;

  always_comb begin
    hit_ld = '0;
    hit_fl = '0;
    hit_ld[instr_frame] = instr_load;
    hit_fl[flush_frame] = flush;
    for (int p = 0; p < NUM_IN; p++) begin
      pf[p] = op_frame[p*FRAME_W +: FRAME_W];
      ps[p] = op_slot[p*2 +: 2];
      pd[p] = op_data[p*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    ack = '0;
    for (int p = 0; p < NUM_IN; p++) begin
      ack[p] = op_req[p] && (st_q[pf[p]] == ST_WAIT) &&
               !slot_busy(vld_q[pf[p]], ps[p]) &&
               !hit_ld[pf[p]] && !hit_fl[pf[p]];
      for (int q = 0; q < p; q++)
        if (op_req[q] && (pf[q] == pf[p]) && (ps[q] == ps[p]))
          ack[p] = 1'b0;
    end
  end

  assign op_ack = ack;

  // A frame being loaded or flushed this cycle is never offered.
  always_comb begin
    for (int f = 0; f < FRAMES; f++)
      rdy[f] = (st_q[f] == ST_READY) && !hit_ld[f] && !hit_fl[f];
  end

  always_comb begin
    gnt = '0;
    idx = '0;
    for (int i = FRAMES - 1; i >= 0; i--) begin
      idx = rr_q + FRAME_W'(i);
      if (rdy[idx])
        gnt = idx;
    end
    if (lk_q && rdy[lkf_q])
      gnt = lkf_q;
  end

  assign fv         = |rdy;
  assign acc        = fv && fire_ready;
  assign fire_valid = fv;
  assign fire_frame = fv ? gnt : '0;
  assign fire_left  = fv ? lft_q[gnt] : '0;
  assign fire_right = fv ? rgt_q[gnt] : '0;

  always_comb begin
    for (int f = 0; f < FRAMES; f++) begin
      st_d[f]   = st_q[f];
      vld_d[f]  = vld_q[f];
      need_d[f] = need_q[f];
      keep_d[f] = keep_q[f];
      pt_d[f]   = pt_q[f];
      prd_d[f]  = prd_q[f];
      lft_d[f]  = lft_q[f];
      rgt_d[f]  = rgt_q[f];
    end
    sq_d  = '0;
    occ_d = '0;
    rr_d  = acc ? gnt + FRAME_W'(1) : rr_q;
    lk_d  = fv && !fire_ready;
    lkf_d = gnt;

    // Operands for slots outside need are acked but dropped here.
    for (int p = 0; p < NUM_IN; p++) begin
      if (ack[p]) begin
        case (ps[p])
          2'd0: if (need_q[pf[p]][0]) begin
            lft_d[pf[p]]    = pd[p];
            vld_d[pf[p]][0] = 1'b1;
          end
          2'd1: if (need_q[pf[p]][1]) begin
            rgt_d[pf[p]]    = pd[p];
            vld_d[pf[p]][1] = 1'b1;
          end
          2'd2: if (need_q[pf[p]][2]) begin
            prd_d[pf[p]]    = pd[p][0];
            vld_d[pf[p]][2] = 1'b1;
          end
          default: ;
        endcase
      end
    end

    for (int f = 0; f < FRAMES; f++) begin
      if (hit_fl[f]) begin
        st_d[f]  = ST_EMPTY;
        vld_d[f] = '0;
      end else if (hit_ld[f]) begin
        need_d[f] = instr_need;
        keep_d[f] = instr_keep;
        pt_d[f]   = instr_pred_true;
        vld_d[f]  = vld_q[f] & instr_keep & instr_need;
        st_d[f]   = eval_st(vld_d[f], instr_need,
                            instr_pred_true, prd_q[f]);
        sq_d[f]   = (st_d[f] == ST_DONE);
      end else if (revit && (st_q[f] != ST_EMPTY)) begin
        st_d[f]  = ST_WAIT;
        vld_d[f] = vld_d[f] & (keep_q[f] | ~vld_q[f]);
      end else if (st_q[f] == ST_WAIT) begin
        st_d[f] = eval_st(vld_d[f], need_q[f], pt_q[f], prd_d[f]);
        sq_d[f] = (st_d[f] == ST_DONE);
      end else if ((st_q[f] == ST_READY) && acc &&
                   (gnt == FRAME_W'(f))) begin
        st_d[f] = ST_DONE;
      end
      if (st_d[f] != ST_EMPTY)
        occ_d = occ_d + (FRAME_W+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int f = 0; f < FRAMES; f++) begin
        st_q[f]   <= ST_EMPTY;
        vld_q[f]  <= '0;
        need_q[f] <= '0;
        keep_q[f] <= '0;
        pt_q[f]   <= 1'b0;
        prd_q[f]  <= 1'b0;
        lft_q[f]  <= '0;
        rgt_q[f]  <= '0;
      end
      sq_q  <= '0;
      occ_q <= '0;
      rr_q  <= '0;
      lk_q  <= 1'b0;
      lkf_q <= '0;
    end else begin
      for (int f = 0; f < FRAMES; f++) begin
        st_q[f]   <= st_d[f];
        vld_q[f]  <= vld_d[f];
        need_q[f] <= need_d[f];
        keep_q[f] <= keep_d[f];
        pt_q[f]   <= pt_d[f];
        prd_q[f]  <= prd_d[f];
        lft_q[f]  <= lft_d[f];
        rgt_q[f]  <= rgt_d[f];
      end
      sq_q  <= sq_d;
      occ_q <= occ_d;
      rr_q  <= rr_d;
      lk_q  <= lk_d;
      lkf_q <= lkf_d;
    end
  end

  assign squash_mask = sq_q;
  assign occupancy   = occ_q;

endmodule

// File: tb/tb_reservation_station_mf.sv
// Bench for reservation_station_mf: directed scenarios plus
// random traffic checked against a frame-level model every cycle.
module tb_reservation_station_mf;
  localparam int F  = 8;
  localparam int N  = 2;
  localparam int W  = 64;
  localparam int FW = 3;
  localparam int E  = 0, WT = 1, RD = 2, DN = 3;

  logic clk, rst_n;
  logic instr_load, instr_pred_true;
  logic [FW-1:0] instr_frame, fire_frame, flush_frame;
  logic [2:0] instr_need, instr_keep;
  logic [N-1:0] op_req, op_ack;
  logic [N*FW-1:0] op_frame;
  logic [N*2-1:0] op_slot;
  logic [N*W-1:0] op_data;
  logic fire_valid, fire_ready, morph_s, revitalize, flush;
  logic [W-1:0] fire_left, fire_right;
  logic [F-1:0] squash_mask;
  logic [FW:0] occupancy;

  reservation_station_mf #(.FRAMES(F), .NUM_IN(N), .DATA_W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_load(instr_load), .instr_frame(instr_frame),
    .instr_need(instr_need), .instr_keep(instr_keep),
    .instr_pred_true(instr_pred_true),
    .op_req(op_req), .op_frame(op_frame), .op_slot(op_slot),
    .op_data(op_data), .op_ack(op_ack),
    .fire_valid(fire_valid), .fire_ready(fire_ready),
    .fire_frame(fire_frame), .fire_left(fire_left),
    .fire_right(fire_right), .squash_mask(squash_mask),
    .morph_s(morph_s), .revitalize(revitalize),
    .flush(flush), .flush_frame(flush_frame),
    .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  int         m_st [F];
  logic [2:0] m_vld[F], m_need[F], m_keep[F];
  logic       m_pt [F], m_prd[F];
  logic [W-1:0] m_l[F], m_r[F];
  int         m_rr, m_lockf, m_occ;
  bit         m_lock;
  logic [F-1:0] m_sq;
  logic [N-1:0] e_ack;
  bit         e_fv;
  int         e_ff;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic int pfr(int p);
    return int'(op_frame[p*FW +: FW]);
  endfunction
  function automatic int psl(int p);
    return int'(op_slot[p*2 +: 2]);
  endfunction
  function automatic logic [W-1:0] pdt(int p);
    return op_data[p*W +: W];
  endfunction
  function automatic bit ld_hit(int f);
    return instr_load && (int'(instr_frame) == f);
  endfunction
  function automatic bit fl_hit(int f);
    return flush && (int'(flush_frame) == f);
  endfunction

  task automatic m_reset();
    for (int f = 0; f < F; f++) begin
      m_st[f] = E; m_vld[f] = 0; m_need[f] = 0; m_keep[f] = 0;
      m_pt[f] = 0; m_prd[f] = 0; m_l[f] = 0; m_r[f] = 0;
    end
    m_rr = 0; m_lock = 0; m_lockf = 0; m_sq = 0; m_occ = 0;
  endtask

  task automatic m_comb();
    bit c[F];
    for (int p = 0; p < N; p++) begin
      int f = pfr(p);
      int s = psl(p);
      bit a = op_req[p] && (m_st[f] == WT) && (s != 3);
      if (a) if (m_vld[f][s]) a = 0;
      if (ld_hit(f) || fl_hit(f)) a = 0;
      for (int q = 0; q < p; q++)
        if (op_req[q] && pfr(q) == f && psl(q) == s) a = 0;
      e_ack[p] = a;
    end
    for (int f = 0; f < F; f++)
      c[f] = (m_st[f] == RD) && !ld_hit(f) && !fl_hit(f);
    e_fv = 0; e_ff = 0;
    for (int i = 0; i < F; i++) begin
      int j = (m_rr + i) % F;
      if (!e_fv && c[j]) begin e_fv = 1; e_ff = j; end
    end
    if (m_lock && c[m_lockf]) e_ff = m_lockf;
  endtask

  task automatic m_eval(int f);
    bit pass = !m_need[f][2] || (m_prd[f] == m_pt[f]);
    if (m_vld[f][2] && m_prd[f] != m_pt[f]) begin
      m_st[f] = DN; m_sq[f] = 1;
    end else if ((m_vld[f] & m_need[f]) == m_need[f] && pass)
      m_st[f] = RD;
    else
      m_st[f] = WT;
  endtask

  task automatic m_step();
    logic [2:0] wr[F];
    bit acc;
    m_comb();
    acc = e_fv && fire_ready;
    for (int f = 0; f < F; f++) wr[f] = 0;
    for (int p = 0; p < N; p++) begin
      int f = pfr(p);
      int s = psl(p);
      if (e_ack[p] && m_need[f][s]) begin
        wr[f][s] = 1;
        if (s == 0) m_l[f] = pdt(p);
        if (s == 1) m_r[f] = pdt(p);
        if (s == 2) m_prd[f] = pdt(p)[0];
      end
    end
    m_sq = 0;
    for (int f = 0; f < F; f++) begin
      if (fl_hit(f)) begin
        m_st[f] = E; m_vld[f] = 0;
      end else if (ld_hit(f)) begin
        m_need[f] = instr_need; m_keep[f] = instr_keep;
        m_pt[f] = instr_pred_true;
        m_vld[f] = m_vld[f] & instr_keep & instr_need;
        m_eval(f);
      end else if (morph_s && revitalize && m_st[f] != E) begin
        m_st[f] = WT;
        m_vld[f] = (m_vld[f] & m_keep[f]) | wr[f];
      end else if (m_st[f] == WT) begin
        m_vld[f] = m_vld[f] | wr[f];
        m_eval(f);
      end else if (m_st[f] == RD && acc && e_ff == f)
        m_st[f] = DN;
    end
    if (acc) m_rr = (e_ff + 1) % F;
    m_lock = e_fv && !fire_ready;
    m_lockf = e_ff;
    m_occ = 0;
    for (int f = 0; f < F; f++) if (m_st[f] != E) m_occ++;
  endtask

  task automatic settle();
    #1;
    m_comb();
    chk("ack", op_ack, e_ack);
    chk("fire_valid", fire_valid, e_fv);
    if (e_fv) begin
      chk("fire_frame", fire_frame, e_ff);
      chk("fire_left", fire_left, m_l[e_ff]);
      chk("fire_right", fire_right, m_r[e_ff]);
    end
    chk("squash", squash_mask, m_sq);
    chk("occupancy", occupancy, m_occ);
  endtask

  task automatic tick();
    m_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    instr_load = 0; instr_frame = 0; instr_need = 0; instr_keep = 0;
    instr_pred_true = 0; op_req = 0; op_frame = 0; op_slot = 0;
    op_data = 0; fire_ready = 0; morph_s = 0; revitalize = 0;
    flush = 0; flush_frame = 0;
  endtask

  task automatic ld(int f, logic [2:0] nd, logic [2:0] kp, bit pt);
    instr_load = 1; instr_frame = FW'(f);
    instr_need = nd; instr_keep = kp; instr_pred_true = pt;
  endtask

  task automatic op(int p, int f, int s, logic [W-1:0] d);
    op_req[p] = 1;
    op_frame[p*FW +: FW] = FW'(f);
    op_slot[p*2 +: 2] = 2'(s);
    op_data[p*W +: W] = d;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    m_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int exp_rr[3];
    exp_rr[0] = 0; exp_rr[1] = 4; exp_rr[2] = 6;
    idle();
    rst_n = 0;
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_fv", fire_valid, 0);
    chk("rst_ff", fire_frame, 0);
    chk("rst_fl", fire_left, 0);
    chk("rst_fr", fire_right, 0);
    chk("rst_sq", squash_mask, 0);
    chk("rst_ack", op_ack, 0);
    chk("rst_occ", occupancy, 0);
    rst_n = 1;

    // basic fire
    ld(3, 3'b011, 3'b000, 0); settle(); tick(); idle();
    op(0, 3, 0, 5); op(1, 3, 1, 7); settle();
    chk("basic_ack", op_ack, 2'b11);
    chk("basic_occ", occupancy, 1);
    tick(); idle();
    fire_ready = 1; settle();
    chk("basic_fv", fire_valid, 1);
    chk("basic_ff", fire_frame, 3);
    chk("basic_fl", fire_left, 5);
    chk("basic_fr", fire_right, 7);
    tick(); idle(); settle();
    chk("basic_done_fv", fire_valid, 0);
    chk("basic_done_occ", occupancy, 1);
    do_reset();

    // port conflict
    ld(2, 3'b011, 3'b000, 0); settle(); tick(); idle();
    op(0, 2, 0, 11); op(1, 2, 0, 22); settle();
    chk("conf_ack", op_ack, 2'b01);
    tick(); idle();
    op(1, 2, 0, 22); settle();
    chk("conf_retry", op_ack, 2'b00);
    tick(); do_reset();

    // predicate squash then pass
    ld(1, 3'b111, 3'b000, 1); settle(); tick(); idle();
    op(0, 1, 2, 0); settle();
    chk("pred_ack", op_ack, 2'b01);
    tick(); idle(); settle();
    chk("pred_sq", squash_mask, 8'h02);
    chk("pred_nofire", fire_valid, 0);
    tick(); settle();
    chk("pred_sq_clr", squash_mask, 0);
    tick();
    ld(1, 3'b111, 3'b000, 1); settle(); tick(); idle();
    op(0, 1, 2, 1); op(1, 1, 0, 33); settle();
    chk("pred2_ack", op_ack, 2'b11);
    tick(); idle();
    op(0, 1, 1, 44); settle(); tick(); idle();
    fire_ready = 1; settle();
    chk("pred2_fv", fire_valid, 1);
    chk("pred2_ff", fire_frame, 1);
    chk("pred2_fl", fire_left, 33);
    chk("pred2_fr", fire_right, 44);
    tick(); do_reset();

    // round robin with stall
    ld(0, 3'b000, 3'b000, 0); settle(); tick();
    ld(4, 3'b000, 3'b000, 0); settle(); tick();
    ld(6, 3'b000, 3'b000, 0); settle(); tick(); idle();
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("rr_hold", fire_frame, 0);
      tick();
    end
    fire_ready = 1;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("rr_order", fire_frame, exp_rr[k]);
      tick();
    end
    settle();
    chk("rr_empty", fire_valid, 0);
    tick(); do_reset();

    // revitalize
    ld(5, 3'b011, 3'b010, 0); settle(); tick(); idle();
    op(0, 5, 0, 3); op(1, 5, 1, 9); settle(); tick(); idle();
    fire_ready = 1; settle();
    chk("rev_fr0", fire_right, 9);
    tick(); idle();
    morph_s = 1; revitalize = 1; settle(); tick(); idle();
    morph_s = 1; op(0, 5, 0, 1); settle();
    chk("rev_ack", op_ack, 2'b01);
    chk("rev_wait", fire_valid, 0);
    tick(); idle();
    fire_ready = 1; settle();
    chk("rev_ff", fire_frame, 5);
    chk("rev_fl", fire_left, 1);
    chk("rev_fr", fire_right, 9);
    tick(); idle();
    revitalize = 1; settle(); tick(); idle();
    op(0, 5, 0, 2); settle();
    chk("rev_off_ack", op_ack, 2'b00);
    chk("rev_off_fv", fire_valid, 0);
    tick(); do_reset();

    // flush and mid-issue reset
    ld(5, 3'b011, 3'b000, 0); settle(); tick(); idle();
    flush = 1; flush_frame = 5; op(0, 5, 0, 7); settle();
    chk("fl_ack", op_ack, 2'b00);
    chk("fl_occ_pre", occupancy, 1);
    tick(); idle(); settle();
    chk("fl_occ", occupancy, 0);
    tick();
    ld(3, 3'b000, 3'b000, 0); settle(); tick(); idle(); settle();
    chk("mid_fv", fire_valid, 1);
    rst_n = 0;
    #1;
    chk("mid_rst_fv", fire_valid, 0);
    chk("mid_rst_occ", occupancy, 0);
    m_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      idle();
      if ($urandom_range(0, 3) == 0)
        ld($urandom_range(0, F-1), 3'($urandom_range(0, 7)),
           3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      for (int p = 0; p < N; p++)
        if ($urandom_range(0, 9) < 7)
          op(p, $urandom_range(0, F-1), $urandom_range(0, 3),
             {$urandom, $urandom});
      fire_ready = ($urandom_range(0, 9) < 6);
      morph_s = ($urandom_range(0, 9) < 7);
      revitalize = ($urandom_range(0, 9) == 0);
      flush = ($urandom_range(0, 19) == 0);
      flush_frame = FW'($urandom_range(0, F-1));
      settle();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
